// File: rtl/serial_word_pkg.sv
// Shared constants and types for the serial-to-parallel word receiver.
package serial_word_pkg;
  localparam int   DEFAULT_WIDTH = 4;
  localparam logic LSB_FIRST     = 1'b0;
  localparam logic MSB_FIRST     = 1'b1;

  typedef enum logic {
    ACC_IDLE  = 1'b0,
    ACC_SHIFT = 1'b1
  } acc_state_e;
endpackage

// File: rtl/serial_word_rx_if.sv
// Parallel word handshake: producer drives word/valid, consumer drives ready.
interface serial_word_rx_if #(parameter int WIDTH = serial_word_pkg::DEFAULT_WIDTH);
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;

  modport master (output word_out, output word_valid, input word_ready);
  modport slave  (input word_out, input word_valid, output word_ready);
endinterface

// File: rtl/bit_accum.sv
// Shift accumulator and bit counter; pulses done with the completed word.
module bit_accum
  import serial_word_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             msb_first,
  input  logic             flush,
  output logic [CW-1:0]    bit_count,
  output logic             done,
  output logic [WIDTH-1:0] word
);
  acc_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, shifted;
  logic             dir_q, dir_d, dir_cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACC_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      dir_q   <= LSB_FIRST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dir_d   = dir_q;
    done    = 1'b0;
    // Direction is sampled live only for the first bit of a word.
    dir_cur = (state_q == ACC_IDLE) ? msb_first : dir_q;
    shifted = (dir_cur == MSB_FIRST) ? {acc_q[WIDTH-2:0], bit_in}
                                     : {bit_in, acc_q[WIDTH-1:1]};
    if (flush) begin
      state_d = ACC_IDLE;
      cnt_d   = '0;
      acc_d   = '0;
    end else if (bit_valid) begin
      dir_d = dir_cur;
      if (cnt_q == CW'(WIDTH-1)) begin
        done    = 1'b1;
        state_d = ACC_IDLE;
        cnt_d   = '0;
        acc_d   = '0;
      end else begin
        state_d = ACC_SHIFT;
        cnt_d   = cnt_q + CW'(1);
        acc_d   = shifted;
      end
    end
  end

  assign word      = shifted;
  assign bit_count = cnt_q;
endmodule

// File: rtl/serial_word_rx.sv
// Serial bit receiver: assembles WIDTH-bit words and holds them for a ready/valid consumer.
module serial_word_rx
  import serial_word_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = $clog2(WIDTH+1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bit_in,
  input  logic                bit_valid,
  input  logic                msb_first,
  input  logic                flush,
  output logic [CW-1:0]       bit_count,
  output logic                overrun,
  serial_word_rx_if.master    wbus
);
  logic             done;
  logic [WIDTH-1:0] word_next;
  logic             load;

  bit_accum #(.WIDTH(WIDTH), .CW(CW)) u_accum (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .msb_first (msb_first),
    .flush     (flush),
    .bit_count (bit_count),
    .done      (done),
    .word      (word_next)
  );

  // A draining holder can be refilled on the same edge without a bubble.
  assign load = done && (!wbus.word_valid || wbus.word_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbus.word_out   <= '0;
      wbus.word_valid <= 1'b0;
    end else if (load) begin
      wbus.word_out   <= word_next;
      wbus.word_valid <= 1'b1;
    end else if (wbus.word_valid && wbus.word_ready) begin
      wbus.word_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                            overrun <= 1'b0;
    else if (flush)                                     overrun <= 1'b0;
    else if (done && wbus.word_valid && !wbus.word_ready) overrun <= 1'b1;
  end
endmodule

// File: tb/tb_serial_word_rx.sv
// Directed plus randomized bench for serial_word_rx against a queue-based word model.
module tb_serial_word_rx;
  localparam int W  = 4;
  localparam int CW = $clog2(W+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          bit_in, bit_valid, msb_first, flush;
  logic [CW-1:0] bit_count;
  logic          overrun;

  serial_word_rx_if #(.WIDTH(W)) wif ();

  serial_word_rx #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .msb_first (msb_first),
    .flush     (flush),
    .bit_count (bit_count),
    .overrun   (overrun),
    .wbus      (wif.master)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: bits of the current word in arrival order.
  logic         m_bits[$];
  logic         m_dir;
  logic [W-1:0] m_wout;
  logic         m_wvld;
  logic         m_ovr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_dir  = 1'b0;
    m_wout = '0;
    m_wvld = 1'b0;
    m_ovr  = 1'b0;
  endtask

  task automatic model_edge(input logic bv, input logic b, input logic msb,
                            input logic fl, input logic rdy);
    logic [W-1:0] w;
    logic         complete;
    complete = 1'b0;
    w        = '0;
    if (fl) begin
      m_bits.delete();
      m_ovr = 1'b0;
    end else if (bv) begin
      if (m_bits.size() == 0) m_dir = msb;
      m_bits.push_back(b);
      if (m_bits.size() == W) begin
        for (int i = 0; i < W; i++) begin
          if (m_dir) w[W-1-i] = m_bits[i];
          else       w[i]     = m_bits[i];
        end
        m_bits.delete();
        complete = 1'b1;
      end
    end
    if (complete) begin
      if (!m_wvld || rdy) begin
        m_wout = w;
        m_wvld = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_wvld && rdy) begin
      m_wvld = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".word_out"},   32'(wif.word_out),   32'(m_wout));
    check({tag, ".word_valid"}, 32'(wif.word_valid), 32'(m_wvld));
    check({tag, ".bit_count"},  32'(bit_count),      32'(m_bits.size()));
    check({tag, ".overrun"},    32'(overrun),        32'(m_ovr));
  endtask

  // Called just after a falling edge: drive, clock, then check at the next falling edge.
  task automatic step(input string tag, input logic bv, input logic b, input logic msb,
                      input logic fl, input logic rdy);
    bit_valid      = bv;
    bit_in         = b;
    msb_first      = msb;
    flush          = fl;
    wif.word_ready = rdy;
    model_edge(bv, b, msb, fl, rdy);
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic send_word(input string tag, input logic [W-1:0] seq, input logic msb,
                           input logic rdy_last);
    for (int i = 0; i < W; i++)
      step(tag, 1'b1, seq[W-1-i], msb, 1'b0, (i == W-1) ? rdy_last : 1'b0);
  endtask

  initial begin
    bit_in = 0; bit_valid = 0; msb_first = 0; flush = 0; wif.word_ready = 0;
    rst = 1'b1;
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // LSB-first 1,0,1,1 -> 1101
    step("lsb_b0", 1, 1, 0, 0, 0);
    step("lsb_b1", 1, 0, 0, 0, 0);
    step("lsb_b2", 1, 1, 0, 0, 0);
    step("lsb_b3", 1, 1, 0, 0, 0);
    check("lsb_word", 32'(wif.word_out), 32'h0000_000d);
    step("drain1", 0, 0, 0, 0, 1);

    // MSB-first 1,1,0,0 with msb_first toggled mid-word -> 1100
    step("msb_b0", 1, 1, 1, 0, 0);
    step("msb_b1", 1, 1, 0, 0, 0);
    step("msb_b2", 1, 0, 1, 0, 0);
    step("msb_b3", 1, 0, 0, 0, 0);
    check("msb_word", 32'(wif.word_out), 32'h0000_000c);
    step("drain2", 0, 0, 0, 0, 1);

    // Overrun: 1101 held, 0110 discarded, flush clears overrun only
    send_word("ovr_w1", 4'b1011, 0, 0);
    send_word("ovr_w2", 4'b0110, 0, 0);
    check("ovr_hold", 32'({wif.word_out, overrun}), 32'({4'b1101, 1'b1}));
    step("ovr_flush", 0, 0, 0, 1, 0);
    check("ovr_cleared", 32'({wif.word_valid, overrun}), 32'({1'b1, 1'b0}));

    // Drain and refill on the same edge
    send_word("refill", 4'b0110, 0, 1);
    check("refill_word", 32'({wif.word_out, wif.word_valid, overrun}), 32'({4'b0110, 1'b1, 1'b0}));
    step("drain3", 0, 0, 0, 0, 1);

    // Flush beats a simultaneous bit
    step("fl_b0", 1, 1, 0, 0, 0);
    step("fl_b1", 1, 0, 0, 0, 0);
    step("fl_hit", 1, 1, 0, 1, 0);
    send_word("fl_word", 4'b1110, 0, 0);
    check("fl_result", 32'(wif.word_out), 32'h0000_0007);
    step("drain4", 0, 0, 0, 0, 1);

    // Asynchronous reset between edges mid-word
    step("ar_b0", 1, 1, 0, 0, 0);
    step("ar_b1", 1, 1, 0, 0, 0);
    bit_valid = 0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    send_word("ar_word", 4'b0010, 0, 0);
    check("ar_result", 32'({wif.word_out, wif.word_valid}), 32'({4'b0100, 1'b1}));

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      step("rand",
           logic'($urandom_range(0, 9) < 7),
           logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 19) == 0),
           logic'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
